// File: rtl/ifu_fetch.sv
// ifu_fetch: RV64 instruction-fetch stage. Owns the PC, drives the
// combinational ROM address, and buffers {pc, inst} in a small FIFO
// that decode drains through a valid/ready handshake.
//
// Parameters:
//   RESET_PC    PC loaded on reset
//   FIFO_DEPTH  buffer entries (power of 2, >= 2)
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   inst_addr_o        ROM fetch address (the PC register)
//   inst_i             ROM data, [31:0] is the instruction
//   redirect_valid_i   redirect request from execute
//   redirect_pc_i      redirect target
//   if_valid_o         FIFO head valid
//   if_ready_i         decode accepts head
//   if_pc_o            head PC
//   if_inst_o          head instruction
//   fetch_misalign_o   sticky misaligned-target flag
//
// Optional feature macro: IFU_MISALIGN_CHECK_EN. When defined, a
// misaligned redirect target halts fetch and raises fetch_misalign_o
// until reset or an aligned redirect. When undefined, target bits
// [1:0] are cleared and fetch_misalign_o is tied low.

module ifu_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] inst_addr_o,
    input  logic [63:0] inst_i,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [63:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        fetch_misalign_o
);

    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_MAX = (PW + 1)'(FIFO_DEPTH);

    logic [63:0]   pc_q, pc_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          halted_q, halted_d;

    logic [63:0] pc_mem   [FIFO_DEPTH];
    logic [31:0] inst_mem [FIFO_DEPTH];

    logic deq;
    logic enq;
    logic [63:0] tgt_pc;
    logic        tgt_halt;

    // Upper ROM bits and (in the default build) target bits [1:0]
    // carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{inst_i[63:32], redirect_pc_i[1:0]};

    assign deq = if_valid_o & if_ready_i;
    // A full FIFO may still accept when the head leaves this cycle.
    assign enq = ~redirect_valid_i & ~halted_q
               & ((cnt_q < CNT_MAX) | deq);

`ifdef IFU_MISALIGN_CHECK_EN
    assign tgt_pc   = redirect_pc_i;
    assign tgt_halt = redirect_pc_i[1:0] != 2'b00;
`else
    assign tgt_pc   = {redirect_pc_i[63:2], 2'b00};
    assign tgt_halt = 1'b0;
`endif

    always_comb begin
        pc_d     = pc_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        if (redirect_valid_i) begin
            // Flush; any head handshake this cycle is simply consumed.
            pc_d     = tgt_pc;
            rd_d     = '0;
            wr_d     = '0;
            cnt_d    = '0;
            halted_d = tgt_halt;
        end else begin
            if (enq) begin
                wr_d = wr_q + PTR_ONE;
                pc_d = pc_q + 64'd4;
            end
            if (deq) begin
                rd_d = rd_q + PTR_ONE;
            end
            if (enq & ~deq) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (deq & ~enq) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_q]   <= pc_q;
            inst_mem[wr_q] <= inst_i[31:0];
        end
    end

    assign inst_addr_o      = pc_q;
    assign if_valid_o       = cnt_q != '0;
    assign if_pc_o          = pc_mem[rd_q];
    assign if_inst_o        = inst_mem[rd_q];
    assign fetch_misalign_o = halted_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed and random checks of ifu_fetch against a
// queue-based reference model of the fetch buffer.

module tb_ifu_fetch;

    localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 2;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] inst_addr_o;
    logic [63:0] inst_i;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [63:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        fetch_misalign_o;

    int checks = 0;
    int errors = 0;

    ent_t        q[$];
    logic [63:0] mpc;
    bit          mhalt;
    bit          model_ok = 0;

    always #5 clk = ~clk;

    // ROM: upper half is junk the DUT must ignore.
    assign inst_i = {32'hDEAD_BEEF, inst_addr_o[31:0]};

    ifu_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .inst_addr_o      (inst_addr_o),
        .inst_i           (inst_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .if_valid_o       (if_valid_o),
        .if_ready_i       (if_ready_i),
        .if_pc_o          (if_pc_o),
        .if_inst_o        (if_inst_o),
        .fetch_misalign_o (fetch_misalign_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_chk();
        chk("addr", inst_addr_o, mpc);
        chk("valid", {63'd0, if_valid_o}, {63'd0, q.size() != 0});
        chk("misalign", {63'd0, fetch_misalign_o}, {63'd0, mhalt});
        if (q.size() != 0) begin
            chk("head_pc", if_pc_o, q[0].pc);
            chk("head_inst", {32'd0, if_inst_o}, {32'd0, q[0].inst});
        end
    endtask

    // Check current outputs, apply inputs for one clock, advance model.
    task automatic cycle(input bit rs, input bit rdy, input bit rv,
                         input logic [63:0] tgt);
        bit d;
        if (model_ok) model_chk();
        rst              = rs;
        if_ready_i       = rdy;
        redirect_valid_i = rv;
        redirect_pc_i    = tgt;
        @(posedge clk);
        if (rs) begin
            q.delete();
            mpc   = RPC;
            mhalt = 0;
        end else begin
            d = (q.size() != 0) && rdy;
            if (d) void'(q.pop_front());
            if (rv) begin
                q.delete();
`ifdef IFU_MISALIGN_CHECK_EN
                mpc   = tgt;
                mhalt = (tgt % 4) != 0;
`else
                mpc   = tgt - (tgt % 4);
                mhalt = 0;
`endif
            end else if (!mhalt && q.size() < DEPTH) begin
                q.push_back('{pc: mpc, inst: mpc[31:0]});
                mpc = mpc + 64'd4;
            end
        end
        model_ok = 1;
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] t;
        rst              = 1'b1;
        if_ready_i       = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;

        // Reset
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("rst_addr", inst_addr_o, RPC);
        chk("rst_valid", {63'd0, if_valid_o}, 64'd0);
        chk("rst_mis", {63'd0, fetch_misalign_o}, 64'd0);

        // Streaming with ready=1
        cycle(0, 1, 0, 0);
        chk("s_addr1", inst_addr_o, 64'h8000_0004);
        chk("s_head1", if_pc_o, 64'h8000_0000);
        chk("s_inst1", {32'd0, if_inst_o}, 64'h8000_0000);
        cycle(0, 1, 0, 0);
        chk("s_addr2", inst_addr_o, 64'h8000_0008);
        chk("s_head2", if_pc_o, 64'h8000_0004);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("s_addr4", inst_addr_o, 64'h8000_0010);
        chk("s_head4", if_pc_o, 64'h8000_000C);

        // Backpressure after reset
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        chk("bp_addr", inst_addr_o, 64'h8000_0008);
        chk("bp_head", if_pc_o, 64'h8000_0000);
        chk("bp_valid", {63'd0, if_valid_o}, 64'd1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);

        // Redirect while full and ready=1
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 64'h8000_0100);
        chk("rd_valid", {63'd0, if_valid_o}, 64'd0);
        chk("rd_addr", inst_addr_o, 64'h8000_0100);
        cycle(0, 0, 0, 0);
        chk("rd_head", if_pc_o, 64'h8000_0100);
        chk("rd_valid2", {63'd0, if_valid_o}, 64'd1);

        // Reset and redirect together
        cycle(1, 1, 1, 64'h8000_0400);
        chk("rr_addr", inst_addr_o, RPC);
        chk("rr_valid", {63'd0, if_valid_o}, 64'd0);

        // Misaligned redirect
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 64'h8000_0102);
        cycle(0, 1, 0, 0);
`ifdef IFU_MISALIGN_CHECK_EN
        chk("mis_flag", {63'd0, fetch_misalign_o}, 64'd1);
        chk("mis_valid", {63'd0, if_valid_o}, 64'd0);
        cycle(0, 1, 1, 64'h8000_0200);
        cycle(0, 1, 0, 0);
        chk("mis_clr", {63'd0, fetch_misalign_o}, 64'd0);
        chk("mis_head", if_pc_o, 64'h8000_0200);
`else
        chk("mis_head", if_pc_o, 64'h8000_0100);
        chk("mis_flag", {63'd0, fetch_misalign_o}, 64'd0);
`endif

        // PC wrap
        cycle(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_addr0", inst_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(0, 1, 0, 0);
        chk("wr_addr1", inst_addr_o, 64'h0);
        chk("wr_head", if_pc_o, 64'hFFFF_FFFF_FFFF_FFFC);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            t = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) t[63:32] = 32'd0;
            cycle($urandom_range(0, 49) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, t);
        end
        model_chk();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
